// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, default keystream constants and Gray helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/ps2_lfsr.sv
// ps2_lfsr: Fibonacci keystream register clocked by the keyboard clock
module ps2_lfsr #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = ps2_pkg::DEF_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED = ps2_pkg::DEF_SEED
) (
    input  logic              ps2_nclk,
    input  logic              nReset,
    input  logic              step,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q;

    // shift in the tap parity whenever the caller asks for a step; reset restores the seed
    always_ff @(negedge ps2_nclk or negedge nReset) begin
        if (!nReset) lfsr_q <= LFSR_SEED;
        else if (step) lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/ps2_crypt_rx.sv
// ps2_crypt_rx: PS/2 frame receiver with optional keystream encryption into a small ring buffer
module ps2_crypt_rx import ps2_pkg::*; #(
    parameter int                DATA_W    = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED = '1,
    parameter int                DEPTH     = 4,
    parameter bit                STEP_ALL  = 1'b0
) (
    input  logic                       ps2_nclk,
    input  logic                       nReset,
    input  logic                       ndata,
    input  logic                       crypt_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     wr_ptr_gray,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic [7:0]                 err_count,
    output logic                       busy,
    output logic                       led
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                crypt_q, crypt_d;
    logic                par_q, par_d;
    logic [AW:0]         wr_ptr_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                perr_q, ferr_q, led_q;
    logic [7:0]          err_q;
    logic [LFSR_W-1:0]   lfsr;
    logic [DATA_W-1:0]   key;
    logic                step, par_ok, good, at_stop;

    // keystream steps per data bit so it tracks the AVR-side decryptor, or on every edge in legacy mode
    assign step    = STEP_ALL || state_q == DATA;
    assign key     = DATA_W'(lfsr >> (LFSR_W - DATA_W));
    assign par_ok  = ^sr_q ^ par_q;
    assign at_stop = state_q == STOP;
    assign good    = par_ok && ndata;

    ps2_lfsr #(
        .LFSR_W   (LFSR_W),
        .LFSR_TAPS(LFSR_TAPS),
        .LFSR_SEED(LFSR_SEED)
    ) u_lfsr (
        .ps2_nclk(ps2_nclk),
        .nReset  (nReset),
        .step    (step),
        .lfsr    (lfsr)
    );

    // frame sequencing: start bit, LSB-first data, parity, stop
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        crypt_d = crypt_q;
        par_d   = par_q;
        case (state_q)
            IDLE: if (!ndata) begin
                state_d = DATA;
                cnt_d   = '0;
                crypt_d = crypt_en;
            end
            DATA: begin
                sr_d    = {ndata, sr_q[DATA_W-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == CW'(DATA_W - 1) ? PARITY : DATA;
            end
            PARITY: begin
                par_d   = ndata;
                state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // frame state and shift register
    always_ff @(negedge ps2_nclk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            crypt_q <= 1'b0;
            par_q   <= 1'b0;
            led_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            crypt_q <= crypt_d;
            par_q   <= par_d;
            led_q   <= 1'b0;
        end
    end

    // stop-bit evaluation: good frames land in the ring (overwriting the oldest), bad ones are only counted
    always_ff @(negedge ps2_nclk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            err_q    <= '0;
        end else if (at_stop) begin
            perr_q <= !par_ok;
            ferr_q <= !ndata;
            if (good) begin
                mem_q[wr_ptr_q[AW-1:0]] <= crypt_q ? sr_q ^ key : sr_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign rd_data     = mem_q[rd_idx];
    assign wr_ptr_gray = PW'(bin2gray(32'(wr_ptr_q)));
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign err_count   = err_q;
    assign busy        = state_q != IDLE;
    assign led         = led_q;

endmodule

// File: tb/tb_ps2_crypt_rx.sv
// tb_ps2_crypt_rx: drives PS/2 frames and checks the receiver against a frame-level model
module tb_ps2_crypt_rx;

    localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_PAR = 3, K_STOP = 4;

    logic       ps2_nclk = 1'b1;
    logic       nReset = 1'b1;
    logic       ndata = 1'b1;
    logic       crypt_en = 1'b0;
    logic [1:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic [2:0] wr_ptr_gray;
    logic       parity_err, frame_err, busy, led;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    logic [7:0] m_buf [4];
    int         m_wp, m_err, m_bits;
    logic       m_perr, m_ferr, m_busy, m_led;
    logic [7:0] f_d;
    logic       f_crypt, f_par_ok;
    int         gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    ps2_crypt_rx dut (
        .ps2_nclk   (ps2_nclk),
        .nReset     (nReset),
        .ndata      (ndata),
        .crypt_en   (crypt_en),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .wr_ptr_gray(wr_ptr_gray),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count),
        .busy       (busy),
        .led        (led)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // keystream byte after n data-bit steps from the all-ones seed (taps 15,13,12,10)
    function automatic logic [7:0] key_at(input int n);
        logic [15:0] l = 16'hFFFF;
        for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l[15:8];
    endfunction

    task automatic do_reset();
        nReset = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) m_buf[i] = '0;
        m_wp = 0; m_err = 0; m_bits = 0;
        m_perr = 0; m_ferr = 0; m_busy = 0; m_led = 1;
        nReset = 1'b1;
        #3;
    endtask

    task automatic pulse(input logic b, input int kind);
        ndata = b;
        rd_idx = 2'($urandom_range(0, 3));
        #5 ps2_nclk = 1'b0;
        #2;
        m_led = 0;
        case (kind)
            K_START: begin m_busy = 1; f_crypt = crypt_en; end
            K_DATA:  m_bits++;
            K_STOP: begin
                m_busy = 0;
                if (f_par_ok && b) begin
                    m_buf[m_wp % 4] = f_crypt ? f_d ^ key_at(m_bits) : f_d;
                    m_wp++;
                    m_perr = 0; m_ferr = 0;
                end else begin
                    m_perr = !f_par_ok;
                    m_ferr = !b;
                    if (m_err < 255) m_err++;
                end
            end
            default: ;
        endcase
        #3 ps2_nclk = 1'b1;
        #5;
    endtask

    task automatic send(input logic [7:0] d, input logic c, input logic bp, input logic bs, input int stop_after);
        logic p;
        p = ~(^d) ^ bp;
        f_d = d;
        f_par_ok = ^{d, p};
        crypt_en = c;
        pulse(1'b0, K_START);
        crypt_en = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            if (i == stop_after) return;
            pulse(d[i], K_DATA);
        end
        pulse(p, K_PAR);
        pulse(!bs, K_STOP);
    endtask

    // every rising edge sits midway between falling edges, where all outputs have settled
    always @(posedge ps2_nclk) begin
        if (cmp_on) begin
            chk("busy", busy, m_busy);
            chk("led", led, m_led);
            chk("wr_ptr_gray", wr_ptr_gray, gray_tab[m_wp % 8]);
            chk("parity_err", parity_err, m_perr);
            chk("frame_err", frame_err, m_ferr);
            chk("err_count", err_count, m_err);
            chk("rd_data", rd_data, m_buf[rd_idx]);
        end
    end

    initial begin
        #1;
        chk("model_key8", key_at(8), 8'hFF);
        chk("model_key16", key_at(16), 8'h00);
        do_reset();
        nReset = 1'b0;
        #1;
        chk("rst_led", led, 1);
        chk("rst_gray", wr_ptr_gray, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_flags", {parity_err, frame_err, busy}, 0);
        nReset = 1'b1;
        #2;
        cmp_on = 1'b1;
        pulse(1'b1, K_IDLE);
        chk("idle_led", led, 0);
        chk("idle_busy", busy, 0);
        chk("idle_gray", wr_ptr_gray, 0);

        send(8'h1C, 0, 0, 0, 99);
        rd_idx = 0; #1;
        chk("plain_byte", rd_data, 8'h1C);
        chk("plain_gray", wr_ptr_gray, 3'b001);

        do_reset();
        send(8'h1C, 1, 0, 0, 99);
        send(8'h1C, 1, 0, 0, 99);
        rd_idx = 0; #1;
        chk("crypt_first", rd_data, 8'hE3);
        rd_idx = 1; #1;
        chk("crypt_second", rd_data, 8'h1C);

        send(8'h1C, 0, 1, 0, 99);
        chk("perr_flag", parity_err, 1);
        chk("perr_count", err_count, 1);
        chk("perr_gray", wr_ptr_gray, 3'b011);
        send(8'h55, 0, 0, 0, 99);
        chk("perr_cleared", parity_err, 0);

        send(8'h1C, 0, 0, 1, 99);
        chk("ferr_flag", frame_err, 1);
        chk("ferr_gray", wr_ptr_gray, 3'b010);
        do_reset();
        for (int i = 0; i < 300; i++) send(8'h1C, 0, 0, 1, 99);
        chk("ferr_saturate", err_count, 8'd255);

        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), 0, 0, 0, 99);
        chk("overrun_gray", wr_ptr_gray, 3'b111);
        rd_idx = 0; #1;
        chk("overrun_buf0", rd_data, 8'h05);

        do_reset();
        send(8'hA7, 1, 0, 0, 4);
        do_reset();
        chk("abort_gray", wr_ptr_gray, 0);
        send(8'h1C, 1, 0, 0, 99);
        rd_idx = 0; #1;
        chk("abort_seed", rd_data, 8'hE3);
        chk("abort_no_err", err_count, 0);

        for (int n = 0; n < 250; n++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) pulse(1'b1, K_IDLE);
            else if (r == 1) begin
                send(8'($urandom), 1'($urandom), 0, 0, $urandom_range(0, 7));
                do_reset();
            end else send(8'($urandom), 1'($urandom), r == 2, r == 3 || r == 4, 99);
        end

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_crypt_rx.md
# ps2_crypt_rx

Parametrised PS/2 keyboard frame receiver with optional LFSR stream encryption and a small ring buffer. Runs entirely on the keyboard clock. Decodes start, data, parity and stop bits, checks odd parity and framing, and XORs each good byte with an LFSR keystream. Results are stored in a DEPTH-entry buffer that the AVR-side logic reads asynchronously through a Gray-coded write pointer.

## Interface
- DATA_W, 8, data bits per frame
- LFSR_W, 16, keystream register width; must be ≥ DATA_W
- LFSR_TAPS, 16'hB400, feedback mask (bits 15,13,12,10)
- LFSR_SEED, '1, reset value; must be non-zero
- DEPTH, 4, ring buffer entries; power of 2, ≥ 2
- STEP_ALL, 0, 1 = LFSR steps on every ps2_nclk edge (legacy mode); 0 = steps on data bits only

Ports:
- ps2_nclk  in  1  keyboard clock. Every flop updates on its falling edge.
- nReset  in  1  reset, asynchronous, active-low
- ndata  in  1  keyboard data, active high
- crypt_en  in  1  encryption enable; sampled at the start bit
- rd_idx  in  $clog2(DEPTH)  read index
- rd_data  out  DATA_W  buffer[rd_idx], combinational
- wr_ptr_gray  out  $clog2(DEPTH)+1  Gray-coded write pointer
- parity_err  out  1  last completed frame had bad parity
- frame_err  out  1  last completed frame had stop bit = 0
- err_count  out  8  saturating count of bad frames
- busy  out  1  frame in progress
- led  out  1  reset indicator

## Operation
- **States**
  - IDLE: ndata=0 → DATA, bit_cnt←0, crypt latched←crypt_en. ndata=1 → stay (spurious edge ignored).
  - DATA: shift LSB-first, sr←{ndata, sr[DATA_W-1:1]}. On the DATA_W-th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: → IDLE and evaluate the frame.
- **Frame evaluation at the STOP edge**
  - Good frame: ^sr ^ parity = 1 and ndata = 1.
    - Write buffer[wr_ptr[lsbs]] ← sr ^ key if crypt latched, else sr.
    - Increment wr_ptr.
    - Clear both error flags.
  - Bad frame: no write. Set parity_err and/or frame_err (both can be set). Increment err_count, saturating at 255.
- **Keystream**
  - key = lfsr[LFSR_W-1 -: DATA_W], taken before the STOP edge update.
  - LFSR step: lfsr←{lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - STEP_ALL=0: steps once per DATA bit edge, including frames later rejected, so it stays aligned with the AVR decryptor bit count.
  - STEP_ALL=1: steps on every edge.
- **Overrun**
  - No backpressure: a write always proceeds, and the oldest entry is overwritten.
  - The consumer detects overrun when wr_ptr minus its read pointer exceeds DEPTH.
- **Other outputs**
  - busy = 1 in DATA, PARITY and STOP.
  - led = 1 from reset until the first falling edge, then 0.

## Timing
- **Reset values:** state IDLE, lfsr=LFSR_SEED, wr_ptr=0, wr_ptr_gray=0, parity_err=0, frame_err=0, err_count=0, busy=0, led=1. Buffer contents are cleared to 0.
- **Latency:** a frame is 11 edges for DATA_W=8 (start + data + parity + stop).
  - The buffer entry and wr_ptr_gray update together on the stop-bit edge.
  - Because the keyboard clock then idles, the outputs stay static until the next frame.
- **Gray pointer:** wr_ptr_gray changes exactly 1 bit per good frame. It wraps at 2·DEPTH (binary).
- **Error flags:** hold until the next frame completes.
- **Reset mid-frame:** the frame is aborted with no write and no error count. The LFSR returns to the seed.
- **Read port:** rd_data is valid for any entry written at least one edge earlier. Reading the entry being written in the same edge returns the old value until the edge.

## Structure
- **Package ps2_pkg:**
  - state enum (IDLE, DATA, PARITY, STOP)
  - default tap and seed constants
  - bin2gray function
- **Sub-module ps2_lfsr:** parameters LFSR_W, LFSR_TAPS, LFSR_SEED; inputs step and ps2_nclk/nReset; output lfsr.
- **Top level:** the FSM, shift register, buffer and counters.

## Test plan
- **Reset:** assert nReset → led=1, wr_ptr_gray=0, err_count=0, both flags 0. After one idle edge with ndata=1 → led=0, state still IDLE, no write.
- **Plain byte:** crypt_en=0, send 0x1C with parity 0 → rd_data[idx0]=0x1C, wr_ptr_gray=3'b001.
- **Encrypted bytes:** reset, crypt_en=1, STEP_ALL=0, send 0x1C twice.
  - First entry = 0xE3 (key 0xFF, lfsr 16'hFF00).
  - Second entry = 0x1C (lfsr 16'h001B, key 0x00).
- **Parity error:** send 0x1C with parity 1 → parity_err=1, err_count=1, wr_ptr unchanged. A following good frame clears parity_err.
- **Framing error:** send 0x1C with stop bit 0 → frame_err=1, no write. Repeat 300 times → err_count=255.
- **Overrun and reset:**
  - DEPTH=4: send bytes 0x01..0x05 → wr_ptr_gray=3'b111 and buffer[0]=0x05.
  - Pulse nReset after the 4th data bit of a frame → no write, lfsr=seed.
